// File: rtl/approx_mul_ha_pipe.sv
// approx_mul_ha_pipe: 3-stage unsigned approximate multiplier built from paired half-adder arrays.
// Optional build macro APPROX_MUL_ERR_STAT_EN adds an exact shadow product and the err_cnt statistic.

module approx_mul_ha_pair #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int K           = 0
) (
    input  logic [1:0]       xb,
    input  logic [WIDTH-1:0] y,
    input  logic             m_or,
    input  logic             m_elim,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   cry
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    assign a = y & {WIDTH{xb[0]}};
    assign b = y & {WIDTH{xb[1]}};

    // Outputs are at weights local to 2*K; carries land one column above their cell.
    assign sum[0]     = a[0];
    assign sum[WIDTH] = b[WIDTH-1];
    assign cry[1:0]   = 2'b00;

    for (genvar c = 1; c < WIDTH; c++) begin : g_cell
        localparam bit ZONE = (2 * K + c) < APPROX_COLS;
        logic ha_s;
        logic ha_c;

        always_comb begin
            ha_s = a[c] ^ b[c-1];
            ha_c = a[c] & b[c-1];
            if (ZONE && m_or) begin
                ha_s = a[c] | b[c-1];
                ha_c = 1'b0;
            end else if (ZONE && m_elim) begin
                ha_s = 1'b0;
                ha_c = 1'b0;
            end
        end

        assign sum[c]   = ha_s;
        assign cry[c+1] = ha_c;
    end
endmodule

module approx_mul_ha_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
`ifdef APPROX_MUL_ERR_STAT_EN
    ,
    output logic [CNT_W-1:0]   err_cnt
`endif
);
    localparam int NP     = WIDTH / 2;
    localparam int PW     = 2 * WIDTH;
    localparam int STAGES = 3;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [1:0]       mode;
    } req_t;

    if ((WIDTH % 2) != 0 || WIDTH < 4 || APPROX_COLS < 0 || APPROX_COLS > PW - 2 || CNT_W < 1)
    begin : g_bad_cfg
        $error("approx_mul_ha_pipe: illegal parameter combination");
    end

    logic                   en;
    logic [STAGES:1]        vld_pipe;
    req_t                   s1_req;
    logic                   m_or;
    logic                   m_elim;
    logic [NP-1:0][WIDTH:0] ha_sum;
    logic [NP-1:0][WIDTH:0] ha_cry;
    logic [NP-1:0][WIDTH:0] s2_sum;
    logic [NP-1:0][WIDTH:0] s2_cry;
    logic [PW-1:0]          red;

    // One global enable: the whole pipe advances only when the output slot is free or draining.
    assign en        = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_req <= '0;
        end else if (en) begin
            s1_req <= {x, y, mode};
        end
    end

    // Reserved mode 3 decodes to neither flag and therefore runs exact.
    assign m_or   = (s1_req.mode == 2'd1);
    assign m_elim = (s1_req.mode == 2'd2);

    for (genvar k = 0; k < NP; k++) begin : g_pair
        approx_mul_ha_pair #(
            .WIDTH       (WIDTH),
            .APPROX_COLS (APPROX_COLS),
            .K           (k)
        ) u_pair (
            .xb     (s1_req.x[2*k+1:2*k]),
            .y      (s1_req.y),
            .m_or   (m_or),
            .m_elim (m_elim),
            .sum    (ha_sum[k]),
            .cry    (ha_cry[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum <= '0;
            s2_cry <= '0;
        end else if (en) begin
            s2_sum <= ha_sum;
            s2_cry <= ha_cry;
        end
    end

    always_comb begin
        red = '0;
        for (int k = 0; k < NP; k++) begin
            red = red + (PW'(s2_sum[k]) << (2 * k)) + (PW'(s2_cry[k]) << (2 * k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= red;
        end
    end

`ifdef APPROX_MUL_ERR_STAT_EN
    logic [PW-1:0] s2_exact;
    logic [PW-1:0] s3_exact;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_exact <= '0;
            s3_exact <= '0;
        end else if (en) begin
            s2_exact <= PW'(s1_req.x) * PW'(s1_req.y);
            s3_exact <= s2_exact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && (p != s3_exact) && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Self-checking bench for approx_mul_ha_pipe: directed plan cases, stall, mid-reset and a
// randomized stream scored against a loss-based arithmetic model.

module tb_approx_mul_ha_pipe;
    localparam int WIDTH       = 8;
    localparam int APPROX_COLS = 4;
    localparam int CNT_W       = 16;
    localparam int PW          = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic [1:0]       mode = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [PW-1:0]    p;
`ifdef APPROX_MUL_ERR_STAT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int unsigned err_exp = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exact_q[$];
    logic [PW-1:0] got_q[$];

    always #5 clk = ~clk;

    approx_mul_ha_pipe #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
`ifdef APPROX_MUL_ERR_STAT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    // Exact product minus what each approximated cell loses: OR drops a&b, eliminate drops a+b.
    function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] yb,
                                              input logic [1:0] m);
        int unsigned acc;
        int unsigned pa;
        int unsigned pb;
        int w;
        acc = 32'(xa) * 32'(yb);
        for (int k = 0; k < WIDTH / 2; k++) begin
            for (int c = 1; c < WIDTH; c++) begin
                w  = 2 * k + c;
                pa = 32'(yb[c] & xa[2*k]);
                pb = 32'(yb[c-1] & xa[2*k+1]);
                if (w < APPROX_COLS) begin
                    if (m == 2'd1)      acc = acc - ((pa & pb) << w);
                    else if (m == 2'd2) acc = acc - ((pa + pb) << w);
                end
            end
        end
        return acc[PW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_and_check(input string tag);
        logic [PW-1:0] e;
        logic [PW-1:0] ex;
        chk({tag, "_expected"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            ex = exact_q.pop_front();
            chk(tag, 32'(p), 32'(e));
            if (e != ex) err_exp++;
        end
    endtask

    task automatic run_single(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                              input logic [1:0] mv, input logic [PW-1:0] expv, input string tag);
        @(negedge clk);
        x = xv; y = yv; mode = mv; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_accept"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; x = WIDTH'($urandom); y = WIDTH'($urandom); mode = 2'($urandom);
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_lat3"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(p), 32'(expv));
        @(negedge clk);
        chk({tag, "_done"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_p", 32'(p), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef APPROX_MUL_ERR_STAT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

        // Directed plan cases
        run_single(8'hFF, 8'hFF, 2'd0, 16'hFE01, "m0_ff_ff");
`ifdef APPROX_MUL_ERR_STAT_EN
        chk("err_after_m0", 32'(err_cnt), 32'd0);
`endif
        run_single(8'hFF, 8'hFF, 2'd2, 16'hFDD5, "m2_ff_ff");
`ifdef APPROX_MUL_ERR_STAT_EN
        chk("err_after_m2", 32'(err_cnt), 32'd1);
`endif
        run_single(8'hFF, 8'hFF, 2'd1, 16'hFDEB, "m1_ff_ff");
        run_single(8'h01, 8'hFF, 2'd2, 16'h00F1, "m2_01_ff");
        run_single(8'h00, 8'hA5, 2'd2, 16'h0000, "m2_00_a5");
        run_single(8'hFF, 8'hFF, 2'd3, 16'hFE01, "m3_reserved");
`ifdef APPROX_MUL_ERR_STAT_EN
        chk("err_after_dir", 32'(err_cnt), 32'd3);
`endif

        // Back-to-back beats, then output stall with a new beat waiting at the input
        @(negedge clk);
        in_valid = 1'b1; x = 8'd3; y = 8'd5; mode = 2'd0; out_ready = 1'b1;
        @(negedge clk);
        x = 8'd7; y = 8'd9;
        @(negedge clk);
        x = 8'hFF; y = 8'h02;
        @(negedge clk);
        x = 8'h10; y = 8'h10; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_p_held", 32'(p), 32'd15);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("stall_release_ready", 32'(in_ready), 32'd1);
        got_q.delete();
        for (int i = 0; i < 12 && got_q.size() < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
            end
            if (out_valid) got_q.push_back(p);
        end
        in_valid = 1'b0;
        chk("stall_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            chk("stall_order0", 32'(got_q[0]), 32'd15);
            chk("stall_order1", 32'(got_q[1]), 32'd63);
            chk("stall_order2", 32'(got_q[2]), 32'd510);
            chk("stall_order3", 32'(got_q[3]), 32'd256);
        end
        repeat (3) begin
            @(negedge clk);
            chk("stall_no_dup", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset with beats in flight
        @(negedge clk);
        in_valid = 1'b1; x = 8'hC3; y = 8'h7E; mode = 2'd1; out_ready = 1'b0;
        @(negedge clk);
        x = 8'h55; y = 8'hAA; mode = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_p", 32'(p), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef APPROX_MUL_ERR_STAT_EN
        chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized stream with random backpressure
        err_exp = 0;
        exp_q.delete();
        exact_q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
`ifdef APPROX_MUL_ERR_STAT_EN
            chk("rnd_err_cnt", 32'(err_cnt), 32'(err_exp));
`endif
            in_valid  = ($urandom_range(9) < 6);
            x         = WIDTH'($urandom);
            y         = WIDTH'($urandom);
            mode      = 2'($urandom);
            out_ready = ($urandom_range(9) < 7);
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) pop_and_check("rnd_p");
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(x, y, mode));
                exact_q.push_back(PW'(x) * PW'(y));
            end
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) pop_and_check("drain_p");
        end
        in_valid = 1'b0;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("drain_idle", 32'(out_valid), 32'd0);
`ifdef APPROX_MUL_ERR_STAT_EN
        chk("drain_err_cnt", 32'(err_cnt), 32'(err_exp));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/approx_mul_ha_pipe.md
Name: approx_mul_ha_pipe

Overview:
- Parametrised, pipelined successor of the unsigned approximate-multiplier half-adder-array stage.
- Generates WIDTH x WIDTH partial products and pairs rows into WIDTH/2 half-adder arrays.
- Applies a per-transaction approximation mode to the low APPROX_COLS product columns, then reduces the arrays to a final 2*WIDTH product.
- Sits between operand sources and accumulators in approximate datapaths; uses a valid/ready stream interface on both sides.

Parameters:
- WIDTH, 8: operand width. Must be even and >= 4.
- APPROX_COLS, 4: half-adder cells with absolute product weight < APPROX_COLS are approximated. Range 0..2*WIDTH-2; 0 means exact in every mode.
- CNT_W, 16: width of the error-statistics counter (optional feature only).

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: operand beat valid.
- in_ready, out, 1: block can accept a beat.
- x, in, WIDTH: multiplicand, unsigned.
- y, in, WIDTH: multiplier, unsigned.
- mode, in, 2: 0 = exact, 1 = OR-sum, 2 = eliminate, 3 = reserved (treated as exact).
- out_valid, out, 1: product valid.
- out_ready, in, 1: downstream accepts.
- p, out, 2*WIDTH: approximate product.
- err_cnt, out, CNT_W: inexact-result count. Present only with the optional feature.

Behaviour:
- Reset (async assert, sync release):
  - all stage valids = 0; out_valid = 0; p = 0; err_cnt = 0.
  - in_ready = 1 in the first cycle after release.
- Pipeline, 3 stages:
  - S1 registers x, y, mode.
  - S2 registers the HA-array outputs.
  - S3 registers p.
  - Latency 3 cycles from in_valid & in_ready to out_valid with no stall.
  - Throughput 1 beat/cycle.
- Stall: global, in_ready = !out_valid | out_ready. When in_ready = 0, every stage holds its data and valid. Bubbles do not advance ahead of held data.
- Mode is captured with its operands and travels with them. A mode change between beats affects only later beats.
- HA arrays:
  - Pair k (k = 0..WIDTH/2-1) uses rows a_j = y[j]&x[2k] at weight 2k+j and b_j = y[j]&x[2k+1] at weight 2k+1+j.
  - Cell c (1..WIDTH-1) combines a_c with b_{c-1} at weight w = 2k+c.
  - a_0 and b_{WIDTH-1} always pass through unchanged.
- Cell rule:
  - Exact (w >= APPROX_COLS, or mode 0 or 3): sum = a^b, carry = a&b into weight w+1.
  - Mode 1, w < APPROX_COLS: sum = a|b, carry = 0.
  - Mode 2, w < APPROX_COLS: sum = 0, carry = 0.
- Final reduction: exact unsigned addition of all array outputs at their weights, truncated to 2*WIDTH bits. Overflow is impossible.
- Mid-operation reset: in-flight beats are discarded; no output is produced for them.
- Simultaneous accept and emit (full pipe, out_ready = 1, in_valid = 1): both occur in the same cycle with no bubble.

Optional Feature:
- Macro: APPROX_MUL_ERR_STAT_EN.
- With the macro defined:
  - An exact product is computed alongside and carried down the pipeline.
  - On each output handshake (out_valid & out_ready) where p != exact, err_cnt increments by 1.
  - err_cnt saturates at all-ones and clears only on reset.
- Without the macro: no err_cnt port and no exact-product logic.

Test Plan:
- Defaults, mode 0, x = 0xFF, y = 0xFF, out_ready = 1 -> p = 0xFE01, three cycles after accept.
- Mode 2, x = 0xFF, y = 0xFF -> p = 0xFDD5 (64981). With feature: err_cnt = 1.
- Mode 1, x = 0xFF, y = 0xFF -> p = 0xFDEB (65003).
- Mode 2, x = 0x01, y = 0xFF -> p = 0x00F1. Mode 2, x = 0x00, y = 0xA5 -> p = 0x0000.
- Back-to-back beats (mode 0: 3*5, 7*9, 0xFF*0x02) with out_ready low for cycles 4-6:
  - in_ready = 0 while stalled; p and out_valid held.
  - outputs emitted in order: 15, 63, 510; none dropped or duplicated.
- Assert rst_n low with 2 beats in flight -> out_valid = 0 and p = 0 immediately (asynchronous); no stale output after release; err_cnt = 0.
